// File: rtl/tl_ul_pkg.sv
// Shared TileLink-UL constants and bundle types for the E21 fabric arbiter.
package tl_ul_pkg;

  localparam logic [2:0] A_PUT_FULL        = 3'd0;
  localparam logic [2:0] A_PUT_PARTIAL     = 3'd1;
  localparam logic [2:0] A_GET             = 3'd4;
  localparam logic [2:0] D_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] D_ACCESS_ACK_DATA = 3'd1;

  localparam int OPC_W     = 3;
  localparam int A_PARAM_W = 3;
  localparam int D_PARAM_W = 2;
  localparam int SIZE_W    = 2;
  localparam int ADDR_W    = 32;
  localparam int MASK_W    = 4;
  localparam int DATA_W    = 32;
  localparam int CNT_W     = 4;

  // Source IDs are carried beside these structs because their width depends
  // on the instance (master side SRC_W, slave side SRC_W+1).
  typedef struct packed {
    logic [OPC_W-1:0]     opcode;
    logic [A_PARAM_W-1:0] param;
    logic [SIZE_W-1:0]    size;
    logic [ADDR_W-1:0]    address;
    logic [MASK_W-1:0]    mask;
    logic [DATA_W-1:0]    data;
  } tl_a_t;

  typedef struct packed {
    logic [OPC_W-1:0]     opcode;
    logic [D_PARAM_W-1:0] param;
    logic [SIZE_W-1:0]    size;
    logic                 denied;
    logic                 corrupt;
    logic [DATA_W-1:0]    data;
  } tl_d_t;

endpackage

// File: rtl/tl_ul_out_cnt.sv
// Per-master in-flight request counter: counts accepted A beats minus returned
// D beats, saturating at zero, and reports when the master hits its limit.
module tl_ul_out_cnt
  import tl_ul_pkg::*;
#(
  parameter int MAX_OUT = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic inc,
  input  logic dec,
  output logic full,
  output logic underflow
);

  localparam logic [CNT_W-1:0] MAX_VAL = CNT_W'(MAX_OUT);

  logic [CNT_W-1:0] count;

  assign full      = (count == MAX_VAL);
  assign underflow = dec && (count == '0);

  // An accept and a response in the same cycle cancel; a response with
  // nothing outstanding leaves the count at zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc && !dec) begin
      count <= count + CNT_W'(1);
    end else if (dec && !inc && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/tl_ul_arbiter_2to1.sv
// Two-master to one-slave TileLink-UL arbiter: round-robin A grant into a
// one-entry output register, D responses routed back by the appended source bit.
module tl_ul_arbiter_2to1
  import tl_ul_pkg::*;
#(
  parameter int SRC_W   = 2,
  parameter int MAX_OUT = 4
) (
  input  logic              clock,
  input  logic              reset,

  input  logic              m0_a_valid,
  output logic              m0_a_ready,
  input  logic [2:0]        m0_a_opcode,
  input  logic [2:0]        m0_a_param,
  input  logic [1:0]        m0_a_size,
  input  logic [SRC_W-1:0]  m0_a_source,
  input  logic [31:0]       m0_a_address,
  input  logic [3:0]        m0_a_mask,
  input  logic [31:0]       m0_a_data,
  output logic              m0_d_valid,
  input  logic              m0_d_ready,
  output logic [2:0]        m0_d_opcode,
  output logic [1:0]        m0_d_param,
  output logic [1:0]        m0_d_size,
  output logic [SRC_W-1:0]  m0_d_source,
  output logic              m0_d_denied,
  output logic              m0_d_corrupt,
  output logic [31:0]       m0_d_data,

  input  logic              m1_a_valid,
  output logic              m1_a_ready,
  input  logic [2:0]        m1_a_opcode,
  input  logic [2:0]        m1_a_param,
  input  logic [1:0]        m1_a_size,
  input  logic [SRC_W-1:0]  m1_a_source,
  input  logic [31:0]       m1_a_address,
  input  logic [3:0]        m1_a_mask,
  input  logic [31:0]       m1_a_data,
  output logic              m1_d_valid,
  input  logic              m1_d_ready,
  output logic [2:0]        m1_d_opcode,
  output logic [1:0]        m1_d_param,
  output logic [1:0]        m1_d_size,
  output logic [SRC_W-1:0]  m1_d_source,
  output logic              m1_d_denied,
  output logic              m1_d_corrupt,
  output logic [31:0]       m1_d_data,

  output logic              s_a_valid,
  input  logic              s_a_ready,
  output logic [2:0]        s_a_opcode,
  output logic [2:0]        s_a_param,
  output logic [1:0]        s_a_size,
  output logic [SRC_W:0]    s_a_source,
  output logic [31:0]       s_a_address,
  output logic [3:0]        s_a_mask,
  output logic [31:0]       s_a_data,
  input  logic              s_d_valid,
  output logic              s_d_ready,
  input  logic [2:0]        s_d_opcode,
  input  logic [1:0]        s_d_param,
  input  logic [1:0]        s_d_size,
  input  logic [SRC_W:0]    s_d_source,
  input  logic              s_d_denied,
  input  logic              s_d_corrupt,
  input  logic [31:0]       s_d_data,

  output logic              err_unexpected_d
);

  tl_a_t            slot;
  logic [SRC_W:0]   slot_src;
  logic             slot_valid;
  logic             rr_last;

  tl_a_t            a_in;
  logic [SRC_W:0]   src_in;

  logic full0, full1, under0, under1;
  logic elig0, elig1, grant0, grant1, slot_free;
  logic accept0, accept1;
  logic dst, d_fire0, d_fire1;
  tl_d_t d_bundle;

  // ---------------- A channel arbitration ----------------
  assign elig0     = m0_a_valid && !full0;
  assign elig1     = m1_a_valid && !full1;
  assign grant0    = elig0 && (!elig1 || rr_last);
  assign grant1    = elig1 && (!elig0 || !rr_last);
  assign slot_free = !slot_valid || s_a_ready;

  assign m0_a_ready = slot_free && grant0;
  assign m1_a_ready = slot_free && grant1;
  assign accept0    = m0_a_ready;
  assign accept1    = m1_a_ready;

  // Pick the winning master's beat and tag its source with the master index.
  always_comb begin
    a_in   = '{opcode: m0_a_opcode, param: m0_a_param, size: m0_a_size,
               address: m0_a_address, mask: m0_a_mask, data: m0_a_data};
    src_in = {1'b0, m0_a_source};
    if (accept1) begin
      a_in   = '{opcode: m1_a_opcode, param: m1_a_param, size: m1_a_size,
                 address: m1_a_address, mask: m1_a_mask, data: m1_a_data};
      src_in = {1'b1, m1_a_source};
    end
  end

  // Output slot: load on accept, hold under backpressure, drain when taken.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      slot       <= '0;
      slot_src   <= '0;
      slot_valid <= 1'b0;
      rr_last    <= 1'b1;
    end else if (accept0 || accept1) begin
      slot       <= a_in;
      slot_src   <= src_in;
      slot_valid <= 1'b1;
      rr_last    <= accept1;
    end else if (s_a_ready) begin
      slot_valid <= 1'b0;
    end
  end

  assign s_a_valid   = slot_valid;
  assign s_a_opcode  = slot.opcode;
  assign s_a_param   = slot.param;
  assign s_a_size    = slot.size;
  assign s_a_source  = slot_src;
  assign s_a_address = slot.address;
  assign s_a_mask    = slot.mask;
  assign s_a_data    = slot.data;

  // ---------------- D channel routing ----------------
  assign dst       = s_d_source[SRC_W];
  assign s_d_ready = dst ? m1_d_ready : m0_d_ready;
  assign d_fire0   = s_d_valid && s_d_ready && !dst;
  assign d_fire1   = s_d_valid && s_d_ready && dst;

  assign d_bundle = '{opcode: s_d_opcode, param: s_d_param, size: s_d_size,
                      denied: s_d_denied, corrupt: s_d_corrupt, data: s_d_data};

  assign m0_d_valid   = s_d_valid && !dst;
  assign m0_d_opcode  = d_bundle.opcode;
  assign m0_d_param   = d_bundle.param;
  assign m0_d_size    = d_bundle.size;
  assign m0_d_source  = s_d_source[SRC_W-1:0];
  assign m0_d_denied  = d_bundle.denied;
  assign m0_d_corrupt = d_bundle.corrupt;
  assign m0_d_data    = d_bundle.data;

  assign m1_d_valid   = s_d_valid && dst;
  assign m1_d_opcode  = d_bundle.opcode;
  assign m1_d_param   = d_bundle.param;
  assign m1_d_size    = d_bundle.size;
  assign m1_d_source  = s_d_source[SRC_W-1:0];
  assign m1_d_denied  = d_bundle.denied;
  assign m1_d_corrupt = d_bundle.corrupt;
  assign m1_d_data    = d_bundle.data;

  // ---------------- Outstanding tracking ----------------
  tl_ul_out_cnt #(.MAX_OUT(MAX_OUT)) u_cnt0 (
    .clock(clock), .reset(reset), .inc(accept0), .dec(d_fire0),
    .full(full0), .underflow(under0)
  );

  tl_ul_out_cnt #(.MAX_OUT(MAX_OUT)) u_cnt1 (
    .clock(clock), .reset(reset), .inc(accept1), .dec(d_fire1),
    .full(full1), .underflow(under1)
  );

  // Sticky flag for a response arriving at a master with nothing in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_unexpected_d <= 1'b0;
    end else if (under0 || under1) begin
      err_unexpected_d <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tl_ul_arbiter_2to1.sv
// Self-checking bench for tl_ul_arbiter_2to1: directed scenarios with literal
// expectations followed by randomized traffic against a behavioural model.
module tb_tl_ul_arbiter_2to1;

  localparam int SRC_W   = 2;
  localparam int MAX_OUT = 4;

  logic clock, reset;
  logic m0_a_valid, m0_a_ready, m1_a_valid, m1_a_ready;
  logic [2:0] m0_a_opcode, m0_a_param, m1_a_opcode, m1_a_param;
  logic [1:0] m0_a_size, m1_a_size;
  logic [SRC_W-1:0] m0_a_source, m1_a_source;
  logic [31:0] m0_a_address, m0_a_data, m1_a_address, m1_a_data;
  logic [3:0] m0_a_mask, m1_a_mask;
  logic m0_d_valid, m0_d_ready, m1_d_valid, m1_d_ready;
  logic [2:0] m0_d_opcode, m1_d_opcode;
  logic [1:0] m0_d_param, m0_d_size, m1_d_param, m1_d_size;
  logic [SRC_W-1:0] m0_d_source, m1_d_source;
  logic m0_d_denied, m0_d_corrupt, m1_d_denied, m1_d_corrupt;
  logic [31:0] m0_d_data, m1_d_data;
  logic s_a_valid, s_a_ready;
  logic [2:0] s_a_opcode, s_a_param;
  logic [1:0] s_a_size;
  logic [SRC_W:0] s_a_source;
  logic [31:0] s_a_address, s_a_data;
  logic [3:0] s_a_mask;
  logic s_d_valid, s_d_ready;
  logic [2:0] s_d_opcode;
  logic [1:0] s_d_param, s_d_size;
  logic [SRC_W:0] s_d_source;
  logic s_d_denied, s_d_corrupt;
  logic [31:0] s_d_data;
  logic err_unexpected_d;

  tl_ul_arbiter_2to1 #(.SRC_W(SRC_W), .MAX_OUT(MAX_OUT)) dut (
    .clock(clock), .reset(reset),
    .m0_a_valid(m0_a_valid), .m0_a_ready(m0_a_ready), .m0_a_opcode(m0_a_opcode),
    .m0_a_param(m0_a_param), .m0_a_size(m0_a_size), .m0_a_source(m0_a_source),
    .m0_a_address(m0_a_address), .m0_a_mask(m0_a_mask), .m0_a_data(m0_a_data),
    .m0_d_valid(m0_d_valid), .m0_d_ready(m0_d_ready), .m0_d_opcode(m0_d_opcode),
    .m0_d_param(m0_d_param), .m0_d_size(m0_d_size), .m0_d_source(m0_d_source),
    .m0_d_denied(m0_d_denied), .m0_d_corrupt(m0_d_corrupt), .m0_d_data(m0_d_data),
    .m1_a_valid(m1_a_valid), .m1_a_ready(m1_a_ready), .m1_a_opcode(m1_a_opcode),
    .m1_a_param(m1_a_param), .m1_a_size(m1_a_size), .m1_a_source(m1_a_source),
    .m1_a_address(m1_a_address), .m1_a_mask(m1_a_mask), .m1_a_data(m1_a_data),
    .m1_d_valid(m1_d_valid), .m1_d_ready(m1_d_ready), .m1_d_opcode(m1_d_opcode),
    .m1_d_param(m1_d_param), .m1_d_size(m1_d_size), .m1_d_source(m1_d_source),
    .m1_d_denied(m1_d_denied), .m1_d_corrupt(m1_d_corrupt), .m1_d_data(m1_d_data),
    .s_a_valid(s_a_valid), .s_a_ready(s_a_ready), .s_a_opcode(s_a_opcode),
    .s_a_param(s_a_param), .s_a_size(s_a_size), .s_a_source(s_a_source),
    .s_a_address(s_a_address), .s_a_mask(s_a_mask), .s_a_data(s_a_data),
    .s_d_valid(s_d_valid), .s_d_ready(s_d_ready), .s_d_opcode(s_d_opcode),
    .s_d_param(s_d_param), .s_d_size(s_d_size), .s_d_source(s_d_source),
    .s_d_denied(s_d_denied), .s_d_corrupt(s_d_corrupt), .s_d_data(s_d_data),
    .err_unexpected_d(err_unexpected_d)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int checks = 0;
  int passed = 0;

  // Model state: in-flight counts, last winner, output slot contents, error flag.
  int          mcnt[2];
  bit          mrr;
  bit          mslot_v;
  logic [78:0] mslot;
  bit          merr;

  task automatic check(input string name, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, actual, expected);
  endtask

  task automatic model_reset();
    mcnt[0] = 0; mcnt[1] = 0; mrr = 1'b1; mslot_v = 1'b0; mslot = '0; merr = 1'b0;
  endtask

  function automatic logic [78:0] a_beat(input int i);
    if (i == 0)
      return {m0_a_opcode, m0_a_param, m0_a_size, 1'b0, m0_a_source, m0_a_address, m0_a_mask, m0_a_data};
    return {m1_a_opcode, m1_a_param, m1_a_size, 1'b1, m1_a_source, m1_a_address, m1_a_mask, m1_a_data};
  endfunction

  task automatic idle();
    m0_a_valid = 0; m0_a_opcode = 0; m0_a_param = 0; m0_a_size = 0; m0_a_source = 0;
    m0_a_address = 0; m0_a_mask = 0; m0_a_data = 0; m0_d_ready = 1;
    m1_a_valid = 0; m1_a_opcode = 0; m1_a_param = 0; m1_a_size = 0; m1_a_source = 0;
    m1_a_address = 0; m1_a_mask = 0; m1_a_data = 0; m1_d_ready = 1;
    s_a_ready = 1; s_d_valid = 0; s_d_opcode = 0; s_d_param = 0; s_d_size = 0;
    s_d_source = 0; s_d_denied = 0; s_d_corrupt = 0; s_d_data = 0;
  endtask

  task automatic randomize_inputs(input int d_pct);
    m0_a_valid = ($urandom_range(99) < 60); m1_a_valid = ($urandom_range(99) < 60);
    m0_a_opcode = 3'($urandom); m0_a_param = 3'($urandom); m0_a_size = 2'($urandom);
    m0_a_source = SRC_W'($urandom); m0_a_address = $urandom; m0_a_mask = 4'($urandom);
    m0_a_data = $urandom;
    m1_a_opcode = 3'($urandom); m1_a_param = 3'($urandom); m1_a_size = 2'($urandom);
    m1_a_source = SRC_W'($urandom); m1_a_address = $urandom; m1_a_mask = 4'($urandom);
    m1_a_data = $urandom;
    m0_d_ready = ($urandom_range(99) < 80); m1_d_ready = ($urandom_range(99) < 80);
    s_a_ready = ($urandom_range(99) < 75);
    s_d_valid = ($urandom_range(99) < d_pct);
    s_d_opcode = 3'($urandom); s_d_param = 2'($urandom); s_d_size = 2'($urandom);
    s_d_source = (SRC_W+1)'($urandom); s_d_denied = 1'($urandom);
    s_d_corrupt = 1'($urandom); s_d_data = $urandom;
  endtask

  // Called just after inputs are driven at a falling edge: compare every DUT
  // output with the model, then advance the model across the coming rising edge.
  task automatic step();
    bit el0, el1, free, r0, r1, dst, sdr, d0, d1;
    int win;
    logic [42:0] d_exp;
    #1;
    el0 = m0_a_valid && (mcnt[0] < MAX_OUT);
    el1 = m1_a_valid && (mcnt[1] < MAX_OUT);
    win = -1;
    if (el0 && el1) win = mrr ? 0 : 1;
    else if (el0)   win = 0;
    else if (el1)   win = 1;
    free = !mslot_v || s_a_ready;
    r0 = free && (win == 0);
    r1 = free && (win == 1);
    check("m0_a_ready", 128'(m0_a_ready), 128'(r0));
    check("m1_a_ready", 128'(m1_a_ready), 128'(r1));
    check("s_a_valid", 128'(s_a_valid), 128'(mslot_v));
    if (mslot_v)
      check("s_a_beat", 128'({s_a_opcode, s_a_param, s_a_size, s_a_source, s_a_address, s_a_mask, s_a_data}),
            128'(mslot));
    check("err_unexpected_d", 128'(err_unexpected_d), 128'(merr));
    dst = s_d_source[SRC_W];
    sdr = dst ? m1_d_ready : m0_d_ready;
    check("m0_d_valid", 128'(m0_d_valid), 128'(s_d_valid && !dst));
    check("m1_d_valid", 128'(m1_d_valid), 128'(s_d_valid && dst));
    check("s_d_ready", 128'(s_d_ready), 128'(sdr));
    d_exp = {s_d_opcode, s_d_param, s_d_size, s_d_source[SRC_W-1:0], s_d_denied, s_d_corrupt, s_d_data};
    check("m0_d_fields", 128'({m0_d_opcode, m0_d_param, m0_d_size, m0_d_source, m0_d_denied, m0_d_corrupt, m0_d_data}),
          128'(d_exp));
    check("m1_d_fields", 128'({m1_d_opcode, m1_d_param, m1_d_size, m1_d_source, m1_d_denied, m1_d_corrupt, m1_d_data}),
          128'(d_exp));
    d0 = s_d_valid && sdr && !dst;
    d1 = s_d_valid && sdr && dst;
    if (r0 || r1) begin
      mslot = a_beat(r1 ? 1 : 0); mslot_v = 1'b1; mrr = r1;
    end else if (s_a_ready) begin
      mslot_v = 1'b0;
    end
    if ((d0 && mcnt[0] == 0) || (d1 && mcnt[1] == 0)) merr = 1'b1;
    if (r0 && !d0) mcnt[0]++; else if (d0 && !r0 && mcnt[0] > 0) mcnt[0]--;
    if (r1 && !d1) mcnt[1]++; else if (d1 && !r1 && mcnt[1] > 0) mcnt[1]--;
  endtask

  // Reset held across one rising edge, released at a falling edge.
  task automatic do_reset();
    @(negedge clock);
    idle();
    reset = 1'b1;
    model_reset();
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Directed scenarios, then randomized traffic, then the summary.
  initial begin
    idle();
    reset = 1'b1;
    model_reset();
    repeat (2) @(negedge clock);
    reset = 1'b0;

    @(negedge clock); idle(); step();
    check("rst_s_a_valid", 128'(s_a_valid), 128'(0));
    check("rst_err", 128'(err_unexpected_d), 128'(0));

    // Single master Get
    @(negedge clock); idle();
    m0_a_valid = 1; m0_a_opcode = 3'd4; m0_a_address = 32'h1000; m0_a_source = 2'd1;
    m0_a_mask = 4'hF; m0_a_size = 2'd2;
    step();
    check("single_m0_a_ready", 128'(m0_a_ready), 128'(1));
    @(negedge clock); idle(); step();
    check("single_s_a_valid", 128'(s_a_valid), 128'(1));
    check("single_s_a_source", 128'(s_a_source), 128'(3'b001));
    check("single_s_a_address", 128'(s_a_address), 128'(32'h1000));
    check("single_s_a_opcode", 128'(s_a_opcode), 128'(3'd4));
    @(negedge clock); idle();
    s_d_valid = 1; s_d_opcode = 3'd1; s_d_source = 3'b001; s_d_data = 32'hDEADBEEF;
    step();
    check("single_m0_d_valid", 128'(m0_d_valid), 128'(1));
    check("single_m0_d_data", 128'(m0_d_data), 128'(32'hDEADBEEF));
    check("single_m0_d_source", 128'(m0_d_source), 128'(2'd1));
    check("single_m1_d_valid", 128'(m1_d_valid), 128'(0));

    // Contention: alternating grants starting with master 0
    do_reset();
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clock);
      idle();
      m0_a_valid = 1; m0_a_source = 2'd1; m0_a_address = 32'h100 + k;
      m1_a_valid = 1; m1_a_source = 2'd2; m1_a_address = 32'h200 + k;
      step();
      check("contend_m0_ready", 128'(m0_a_ready), 128'((k % 2) == 0));
      check("contend_m1_ready", 128'(m1_a_ready), 128'((k % 2) == 1));
      if (k > 0) check("contend_s_a_valid", 128'(s_a_valid), 128'(1));
    end

    // Backpressure on a full slot holding master 1's beat
    for (int k = 0; k < 3; k++) begin
      @(negedge clock); idle();
      m0_a_valid = 1; m1_a_valid = 1; m1_a_source = 2'd2; s_a_ready = 0;
      step();
      check("bp_m0_ready", 128'(m0_a_ready), 128'(0));
      check("bp_m1_ready", 128'(m1_a_ready), 128'(0));
      check("bp_s_a_source", 128'(s_a_source), 128'(3'b110));
      check("bp_s_a_address", 128'(s_a_address), 128'(32'h203));
    end
    @(negedge clock); idle();
    m0_a_valid = 1; m1_a_valid = 1; s_a_ready = 1;
    step();
    check("bp_release_m0_ready", 128'(m0_a_ready), 128'(1));

    // Outstanding limit on master 1
    do_reset();
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clock);
      idle(); m1_a_valid = 1; m1_a_opcode = 3'd0; m1_a_address = 32'h40 * k;
      step();
      check("limit_fill_m1_ready", 128'(m1_a_ready), 128'(1));
    end
    @(negedge clock); idle(); m0_a_valid = 1; m1_a_valid = 1; step();
    check("limit_m1_blocked", 128'(m1_a_ready), 128'(0));
    check("limit_m0_proceeds", 128'(m0_a_ready), 128'(1));
    @(negedge clock); idle(); m1_a_valid = 1;
    s_d_valid = 1; s_d_opcode = 3'd0; s_d_source = 3'b100;
    step();
    check("limit_same_cycle_m1_ready", 128'(m1_a_ready), 128'(0));
    check("limit_d_to_m1", 128'(m1_d_valid), 128'(1));
    @(negedge clock); idle(); m1_a_valid = 1; step();
    check("limit_after_d_m1_ready", 128'(m1_a_ready), 128'(1));

    // Spurious response to master 0
    do_reset();
    @(negedge clock); idle(); s_d_valid = 1; s_d_source = 3'b000; s_d_data = 32'h5A5A; step();
    check("spur_forwarded", 128'(m0_d_valid), 128'(1));
    @(negedge clock); idle(); step();
    check("spur_err_set", 128'(err_unexpected_d), 128'(1));
    @(negedge clock); idle(); m0_a_valid = 1; step();
    check("spur_cnt_zero_elig", 128'(m0_a_ready), 128'(1));
    do_reset();
    @(negedge clock); idle(); step();
    check("spur_err_cleared", 128'(err_unexpected_d), 128'(0));

    // Asynchronous reset with a buffered beat under backpressure
    @(negedge clock); idle(); m1_a_valid = 1; step();
    @(negedge clock); idle(); s_a_ready = 0; step();
    check("areset_buffered", 128'(s_a_valid), 128'(1));
    #1 reset = 1'b1;
    #1;
    check("areset_s_a_valid", 128'(s_a_valid), 128'(0));
    model_reset();
    @(negedge clock); reset = 1'b0; idle(); m0_a_valid = 1; m1_a_valid = 1; step();
    check("areset_first_contest_m0", 128'(m0_a_ready), 128'(1));
    check("areset_first_contest_m1", 128'(m1_a_ready), 128'(0));

    // Randomized traffic; sparse responses first so the limit is exercised
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clock);
      reset = 1'b0;
      randomize_inputs(cyc < 1500 ? 15 : 50);
      step();
      if ((cyc % 750) == 749) begin
        #1 reset = 1'b1;
        model_reset();
      end
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/tl_ul_arbiter_2to1.md
Name: tl_ul_arbiter_2to1

Overview:
Two-master to one-slave TileLink-UL arbiter for the E21 core-complex fabric: the stage that shares the slave A/D channel bundle (opcode/param/size/source/address/mask/data) between two requesters. Round-robin A-channel grant, one-entry registered A output, per-master outstanding-request limits, and D-channel routing by an appended source bit.

Parameters:
SRC_W, 2, master-side source ID width; slave-side source is SRC_W+1.
MAX_OUT, 4, maximum in-flight requests per master (1..15).

Ports:
clock  input  1  single clock, rising edge.
reset  input  1  asynchronous, active-high reset.
m0_a_valid/m0_a_ready  input/output  1/1  master 0 A handshake.
m0_a_opcode, m0_a_param, m0_a_size  input  3,3,2  A header fields.
m0_a_source  input  SRC_W  A source ID.
m0_a_address, m0_a_mask, m0_a_data  input  32,4,32  A address, byte mask, data.
m0_d_valid/m0_d_ready  output/input  1/1  master 0 D handshake.
m0_d_opcode, m0_d_param, m0_d_size  output  3,2,2  D header fields.
m0_d_source  output  SRC_W  D source ID, top bit stripped.
m0_d_denied, m0_d_corrupt, m0_d_data  output  1,1,32  D response fields.
m1_*  same set, widths and directions as m0_*, for master 1.
s_a_*  output (s_a_ready input)  same fields as m0_a_*, except s_a_source width SRC_W+1.
s_d_*  input (s_d_ready output)  same fields as m0_d_*, except s_d_source width SRC_W+1.
err_unexpected_d  output  1  sticky error flag.

Behaviour:
- Reset (async, active-high): s_a_valid=0, output A register cleared, both outstanding counters=0, rr_last=1 (master 0 wins first contest), err_unexpected_d=0. A reset mid-transaction discards the buffered A beat. Counters clear; in-flight state is not retained.
- Eligible(i) = mi_a_valid && cnt_i < MAX_OUT.
- Slot free = !s_a_valid || s_a_ready, evaluated the same cycle, so throughput is one beat per cycle.
- Grant:
  - Only one master eligible: that master wins.
  - Both eligible: the master != rr_last wins.
  - mi_a_ready = slot free && grant==i. Combinational from valid, counters and s_a_ready; never asserted for a non-granted master.
- On accept:
  - Fields are registered into the output slot; s_a_valid=1 next cycle, so latency is exactly 1 cycle.
  - s_a_source = {i, mi_a_source}.
  - rr_last <= i.
  - cnt_i increments.
- Output slot holds stable while s_a_valid && !s_a_ready. If nothing is accepted and s_a_ready=1, s_a_valid goes to 0 next cycle.
- D routing (combinational, zero latency):
  - dst = s_d_source[SRC_W].
  - mdst_d_valid = s_d_valid. The other master's d_valid = 0.
  - s_d_ready = mdst_d_ready.
  - Header/data fields are fanned out to both masters; d_source = s_d_source[SRC_W-1:0].
- On D fire to master i: cnt_i decrements, saturating at 0. If cnt_i was already 0, err_unexpected_d is set and stays set until reset; the response is still forwarded.
- Same cycle A accept and D fire for one master: cnt_i unchanged.
- Counter at MAX_OUT: the master is ineligible and its a_ready=0, even if a D fire for it occurs that cycle. It becomes eligible the next cycle.
- No combinational path from mi_a_* to s_a_*. The D path is purely combinational.

Decomposition:
- Package tl_ul_pkg:
  - A/D opcode localparams (Get=4, PutFull=0, PutPartial=1, AccessAck=0, AccessAckData=1).
  - Field-width constants.
  - Packed struct typedefs tl_a_t and tl_d_t.
- Sub-module tl_ul_out_cnt: per-master saturating in-flight counter with inc/dec/full/underflow outputs, instantiated twice.

Test Plan:
- Single master: m0 issues Get, addr 0x1000, source 1. Required: s_a_valid next cycle with s_a_source=3'b001. s_d AccessAckData source 3'b001, data 0xDEADBEEF, appears on m0_d same cycle; m1_d_valid=0.
- Contention: both masters hold valid with s_a_ready=1 continuously. Required grant order 0,1,0,1 and s_a_valid=1 every cycle after the first.
- Backpressure: s_a_ready=0 for 3 cycles with the slot full. Required: s_a fields stable and both mi_a_ready=0. Release → next beat accepted the same cycle.
- Outstanding limit (MAX_OUT=4): m1 issues 4 Puts with no D. Required: m1_a_ready=0 on the 5th while m0 still proceeds. After one D to source 3'b1xx, m1 is accepted the following cycle.
- Spurious D to m0 with cnt_0=0: required err_unexpected_d=1 next cycle, response forwarded, cnt_0 stays 0. Reset clears the flag.
- Async reset with a beat buffered and s_a_ready=0: required s_a_valid=0 immediately, counters=0, and first post-reset contest won by m0.
